cpu_nic: RTL and testbench

//  Memory-mapped network interface answering the four-stage processor's data-memory

---
 rtl/cpu_nic.sv | 135 +++++++++++++
 tb/tb_cpu_nic.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_nic.sv
// rtl/cpu_nic.sv - memory-mapped NIC bridging the CPU load/store port to a mesh router local port
// Output FIFO drains CPU stores to the router; input FIFO buffers router packets for CPU loads.
module cpu_nic #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 2,
  parameter int IN_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int OCW = OPW + 1;
  localparam int IPW = $clog2(IN_DEPTH);
  localparam int ICW = IPW + 1;

  typedef enum logic [1:0] {
    A_IN_BUF   = 2'b00,
    A_IN_STAT  = 2'b01,
    A_OUT_BUF  = 2'b10,
    A_OUT_STAT = 2'b11
  } reg_sel_e;

  logic [0:DATA_W-1] out_mem [OUT_DEPTH];
  logic [0:DATA_W-1] in_mem  [IN_DEPTH];

  logic [OPW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OCW-1:0] out_count, out_count_nxt;
  logic [IPW-1:0] in_wr_ptr, in_rd_ptr;
  logic [ICW-1:0] in_count, in_count_nxt;

  logic out_full, out_empty, out_push, out_pop;
  logic in_full, in_empty, in_push, in_pop;
  logic cpu_load;
  reg_sel_e sel;
  logic [0:DATA_W-1] in_stat, out_stat, load_data;

  assign sel       = reg_sel_e'(addr);
  assign cpu_load  = nicEn && !nicWrEn;

  assign out_full  = (out_count == OCW'(OUT_DEPTH));
  assign out_empty = (out_count == '0);
  assign in_full   = (in_count == ICW'(IN_DEPTH));
  assign in_empty  = (in_count == '0);

  // Full-FIFO stores are judged on pre-edge state, even if the router pops this edge.
  assign out_push  = nicEn && nicWrEn && (sel == A_OUT_BUF) && !out_full;
  assign out_pop   = net_so && net_ro;
  assign in_push   = net_si && net_ri;
  assign in_pop    = cpu_load && (sel == A_IN_BUF) && !in_empty;

  assign net_so    = !out_empty;
  assign net_do    = out_mem[out_rd_ptr];

  always_comb begin
    out_count_nxt = out_count;
    case ({out_push, out_pop})
      2'b10:   out_count_nxt = out_count + OCW'(1);
      2'b01:   out_count_nxt = out_count - OCW'(1);
      default: out_count_nxt = out_count;
    endcase
  end

  always_comb begin
    in_count_nxt = in_count;
    case ({in_push, in_pop})
      2'b10:   in_count_nxt = in_count + ICW'(1);
      2'b01:   in_count_nxt = in_count - ICW'(1);
      default: in_count_nxt = in_count;
    endcase
  end

  // Bit 63 is the LSB of the word; the count field occupies bits 48..55 with its MSB at 48.
  always_comb begin
    in_stat         = '0;
    in_stat[48:55]  = 8'(in_count);
    in_stat[62]     = in_full;
    in_stat[63]     = !in_empty;
    out_stat        = '0;
    out_stat[48:55] = 8'(out_count);
    out_stat[62]    = out_empty;
    out_stat[63]    = out_full;
  end

  always_comb begin
    load_data = '0;
    case (sel)
      A_IN_BUF:   load_data = in_empty ? '0 : in_mem[in_rd_ptr];
      A_IN_STAT:  load_data = in_stat;
      A_OUT_BUF:  load_data = '0;
      A_OUT_STAT: load_data = out_stat;
      default:    load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && out_push) out_mem[out_wr_ptr] <= d_in;
    if (reset && in_push)  in_mem[in_wr_ptr]   <= net_di;
  end

  // A reset edge completes no handshake: every pointer and count is cleared instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_count   <= '0;
      d_out      <= '0;
      net_ri     <= 1'b0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + OPW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OPW'(1);
      if (in_push)  in_wr_ptr  <= in_wr_ptr + IPW'(1);
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + IPW'(1);
      out_count <= out_count_nxt;
      in_count  <= in_count_nxt;
      if (cpu_load) d_out <= load_data;
      net_ri <= (in_count_nxt != ICW'(IN_DEPTH));
    end
  end

endmodule

// File: tb/tb_cpu_nic.sv
// tb/tb_cpu_nic.sv - directed and randomized bench for cpu_nic against a queue-based model
// The model tracks both FIFOs as queues and derives every output from their sizes and heads.
module tb_cpu_nic;

  localparam int OUT_DEPTH = 2;
  localparam int IN_DEPTH  = 2;

  logic        clk;
  logic        reset;
  logic        nicEn, nicWrEn;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_do, net_di;
  logic        net_so, net_ro, net_si, net_ri;

  cpu_nic #(.DATA_W(64), .OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH)) dut (
    .clk(clk), .reset(reset), .nicEn(nicEn), .nicWrEn(nicWrEn), .addr(addr),
    .d_in(d_in), .d_out(d_out), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] stat_word(input int cnt, input bit b1, input bit b0);
    return (64'(cnt) << 8) | (64'(b1) << 1) | 64'(b0);
  endfunction

  logic [63:0] m_out[$];
  logic [63:0] m_in[$];
  logic [63:0] m_dout = 64'h0;
  bit          m_ri   = 1'b0;

  wire st_out = nicEn && nicWrEn && (addr == 2'b10);
  wire ld_in  = nicEn && !nicWrEn && (addr == 2'b00);

  always @(posedge clk) begin
    if (!reset) begin
      m_out.delete();
      m_in.delete();
      m_dout <= 64'h0;
      m_ri   <= 1'b0;
    end else begin
      if (nicEn && !nicWrEn) begin
        case (addr)
          2'b00:   m_dout <= (m_in.size() != 0) ? m_in[0] : 64'h0;
          2'b01:   m_dout <= stat_word(m_in.size(), m_in.size() == IN_DEPTH, m_in.size() != 0);
          2'b10:   m_dout <= 64'h0;
          default: m_dout <= stat_word(m_out.size(), m_out.size() == 0, m_out.size() == OUT_DEPTH);
        endcase
      end
      if (st_out && m_out.size() < OUT_DEPTH) begin
        if (net_ro && m_out.size() != 0) void'(m_out.pop_front());
        m_out.push_back(d_in);
      end else if (net_ro && m_out.size() != 0) begin
        void'(m_out.pop_front());
      end
      if (net_si && m_ri) begin
        if (ld_in && m_in.size() != 0) void'(m_in.pop_front());
        m_in.push_back(net_di);
      end else if (ld_in && m_in.size() != 0) begin
        void'(m_in.pop_front());
      end
      m_ri <= (m_in.size() != IN_DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("net_so", net_so, m_out.size() != 0);
      if (m_out.size() != 0) check("net_do", net_do, m_out[0]);
      check("net_ri", net_ri, m_ri);
      check("d_out", d_out, m_dout);
    end
  end

  task automatic store(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic load(input logic [1:0] a, output logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    @(negedge clk);
    v = d_out;
    nicEn = 1'b0;
  endtask

  localparam logic [63:0] P1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P3 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] PA = 64'h1111_1111_1111_1111;
  localparam logic [63:0] PB = 64'h2222_2222_2222_2222;
  localparam logic [63:0] PC = 64'h3333_3333_3333_3333;

  logic [63:0] v;

  initial begin
    reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
    net_ro = 1'b0; net_si = 1'b0; net_di = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_so", net_so, 0);
    check("rst_dout", d_out, 0);
    check("rst_ri", net_ri, 0);
    chk_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    check("ri_after_rst", net_ri, 1);
    load(2'b01, v);
    check("in_stat_idle", v, 64'h0);

    // single packet held while router stalls, then one-cycle transfer
    store(2'b10, P1);
    repeat (5) begin
      check("so_hold", net_so, 1);
      check("do_hold", net_do, P1);
      @(negedge clk);
    end
    net_ro = 1'b1;
    @(negedge clk);
    net_ro = 1'b0;
    check("so_after_xfer", net_so, 0);
    load(2'b11, v);
    check("out_stat_empty", v, 64'h2);

    // overflow drops the third store
    store(2'b10, P1);
    store(2'b10, P2);
    store(2'b10, P3);
    load(2'b11, v);
    check("out_stat_full", v, 64'h201);
    check("drain_1", net_do, P1);
    net_ro = 1'b1;
    @(negedge clk);
    check("drain_2", net_do, P2);
    @(negedge clk);
    net_ro = 1'b0;
    check("drain_done", net_so, 0);

    // router fills the input FIFO; third packet waits for a pop
    net_si = 1'b1; net_di = PA;
    @(negedge clk);
    net_di = PB;
    @(negedge clk);
    net_di = PC;
    check("ri_full", net_ri, 0);
    load(2'b01, v);
    check("in_stat_full", v, 64'h203);
    load(2'b00, v);
    check("in_pop_a", v, PA);
    load(2'b00, v);
    check("in_pop_b", v, PB);
    net_si = 1'b0;
    load(2'b01, v);
    check("in_stat_one", v, 64'h101);
    load(2'b00, v);
    check("in_pop_c", v, PC);
    load(2'b00, v);
    check("in_pop_empty", v, 64'h0);

    // same-edge: store into full FIFO while router pops
    store(2'b10, P1);
    store(2'b10, P2);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = P3; net_ro = 1'b1;
    @(negedge clk);
    nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
    load(2'b11, v);
    check("same_edge_out", v, 64'h100);
    check("same_edge_head", net_do, P2);
    net_ro = 1'b1;
    @(negedge clk);
    net_ro = 1'b0;

    // same-edge: router push while CPU pops
    net_si = 1'b1; net_di = PA;
    @(negedge clk);
    net_di = PB;
    load(2'b00, v);
    net_si = 1'b0;
    check("same_edge_pop", v, PA);
    load(2'b01, v);
    check("same_edge_in", v, 64'h101);
    load(2'b00, v);
    check("same_edge_next", v, PB);

    // reset in the middle of pending transfers
    store(2'b10, P3);
    net_si = 1'b1; net_di = PA;
    @(negedge clk);
    net_di = PB;
    @(negedge clk);
    reset = 1'b0; net_ro = 1'b1; net_di = PC;
    @(negedge clk);
    check("mid_rst_so", net_so, 0);
    check("mid_rst_ri", net_ri, 0);
    check("mid_rst_dout", d_out, 0);
    reset = 1'b1; net_ro = 1'b0; net_si = 1'b0;
    @(negedge clk);
    load(2'b01, v);
    check("mid_rst_in", v, 64'h0);
    load(2'b11, v);
    check("mid_rst_out", v, 64'h2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) != 0);
      nicEn   = $urandom_range(0, 1);
      nicWrEn = $urandom_range(0, 1);
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom, $urandom};
      net_ro  = ($urandom_range(0, 2) != 0);
      net_si  = $urandom_range(0, 1);
      net_di  = {$urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b1; nicEn = 1'b0; net_ro = 1'b0; net_si = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
